// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// ASCII control characters used for line-ending handling, and the byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-holding arbiter sharing the UART tx FIFO write port
// between requester 0 (CPU data register) and requester 1 (boot/monitor echo).
// A grant lasts until the owner's last byte or MAX_BURST transfers.
// Optional macro UART_TX_CRLF_EN: inserts a CR ahead of every LF from the
// owner; the CR is not counted in the burst and never split from its LF.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [BYTE_W-1:0] fifo_wdata,
    output logic [1:0]        grant
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_t         state_reg;
    arb_state_t         state_next;
    logic [BURST_W-1:0] burst_reg;
    logic               last_owner_reg;

    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;
    logic               owner_ready;
    logic               accept;
    logic               burst_hit;
    logic               release_grant;

    // Route the current owner's request signals onto a common set of wires.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        case (state_reg)
            ARB_OWN0: begin
                sel_valid = req0_valid;
                sel_last  = req0_last;
                sel_data  = req0_data;
            end
            ARB_OWN1: begin
                sel_valid = req1_valid;
                sel_last  = req1_last;
                sel_data  = req1_data;
            end
            default: ;
        endcase
    end

`ifdef UART_TX_CRLF_EN
    logic cr_sent_reg;
    logic insert_cr;

    // An LF whose CR has not gone out yet is held back while the CR is written.
    assign insert_cr = sel_valid & (sel_data == ASCII_LF) & ~cr_sent_reg;
`endif

    // Output decode: grant, ready, and the zero-latency FIFO write path.
    always_comb begin
        grant       = 2'b00;
        owner_ready = 1'b0;
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;
        if (state_reg != ARB_IDLE) begin
            fifo_wdata = sel_data;
`ifdef UART_TX_CRLF_EN
            if (insert_cr) begin
                fifo_wr    = ~fifo_full;
                fifo_wdata = ASCII_CR;
            end else begin
                owner_ready = sel_valid & ~fifo_full;
                fifo_wr     = owner_ready;
            end
`else
            owner_ready = sel_valid & ~fifo_full;
            fifo_wr     = owner_ready;
`endif
        end
        case (state_reg)
            ARB_OWN0: grant = 2'b01;
            ARB_OWN1: grant = 2'b10;
            default:  grant = 2'b00;
        endcase
        req0_ready = (state_reg == ARB_OWN0) & owner_ready;
        req1_ready = (state_reg == ARB_OWN1) & owner_ready;
    end

    // A requester byte is consumed only when the owner sees ready; CR inserts are not transfers.
    assign accept        = owner_ready;
    assign burst_hit     = (burst_reg == BURST_LAST);
    assign release_grant = accept & (sel_last | burst_hit);

    // Next-state: arbitrate in IDLE, hold ownership until last byte or burst limit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_next = last_owner_reg ? ARB_OWN0 : ARB_OWN1;
                end else if (req0_valid) begin
                    state_next = ARB_OWN0;
                end else if (req1_valid) begin
                    state_next = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (release_grant) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State, burst counter and round-robin history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB_IDLE;
            burst_reg      <= '0;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (release_grant) begin
                burst_reg      <= '0;
                last_owner_reg <= (state_reg == ARB_OWN1);
            end else if (accept) begin
                burst_reg <= burst_reg + BURST_W'(1);
            end
        end
    end

`ifdef UART_TX_CRLF_EN
    // Remember that the CR for the pending LF has been written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cr_sent_reg <= 1'b0;
        end else if (fifo_wr && insert_cr) begin
            cr_sent_reg <= 1'b1;
        end else if (accept) begin
            cr_sent_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_BURST = 4). Expected values are
// hand-derived per cycle. CRLF checks are built when UART_TX_CRLF_EN is defined.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       fifo_full, fifo_wr;
    logic [7:0] fifo_wdata;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.MAX_BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [7:0] d, input logic l);
        req0_valid = v; req0_data = d; req0_last = l;
    endtask

    task automatic drv1(input logic v, input logic [7:0] d, input logic l);
        req1_valid = v; req1_data = d; req1_last = l;
    endtask

    // Write port must stay quiet whenever the FIFO is full.
    always @(negedge clk) begin
        if (reset && fifo_full) check("wr_while_full", {15'd0, fifo_wr}, 16'd0);
    end

    task automatic do_reset();
        reset = 1'b0;
        drv0(1'b0, 8'h00, 1'b0);
        drv1(1'b0, 8'h00, 1'b0);
        fifo_full = 1'b0;
        #1;
        check("rst_grant", {14'd0, grant}, 16'd0);
        check("rst_wr", {15'd0, fifo_wr}, 16'd0);
        check("rst_ready", {14'd0, req1_ready, req0_ready}, 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // ---- Reset then req0 sends "AB" ----
        do_reset();
        drv0(1'b1, 8'h41, 1'b0); #1;
        check("ab_idle_grant", {14'd0, grant}, 16'd0);
        check("ab_idle_wr", {15'd0, fifo_wr}, 16'd0);
        tick(); #1;
        check("ab_grant", {14'd0, grant}, 16'd1);
        check("ab_wr_a", {15'd0, fifo_wr}, 16'd1);
        check("ab_data_a", {8'd0, fifo_wdata}, 16'h41);
        check("ab_rdy0", {15'd0, req0_ready}, 16'd1);
        check("ab_rdy1", {15'd0, req1_ready}, 16'd0);
        tick();
        drv0(1'b1, 8'h42, 1'b1); #1;
        check("ab_wr_b", {15'd0, fifo_wr}, 16'd1);
        check("ab_data_b", {8'd0, fifo_wdata}, 16'h42);
        check("ab_rdy1_b", {15'd0, req1_ready}, 16'd0);
        tick();
        drv0(1'b0, 8'h00, 1'b0); #1;
        check("ab_release", {14'd0, grant}, 16'd0);
        check("ab_rel_wr", {15'd0, fifo_wr}, 16'd0);
        tick();

        // ---- Both valid from reset, single-byte packets ----
        do_reset();
        drv0(1'b1, 8'h30, 1'b1);
        drv1(1'b1, 8'h31, 1'b1); #1;
        check("tie_idle", {14'd0, grant}, 16'd0);
        tick(); #1;
        check("tie_first", {14'd0, grant}, 16'd1);
        check("tie_data0", {8'd0, fifo_wdata}, 16'h30);
        check("tie_rdy1_held", {15'd0, req1_ready}, 16'd0);
        tick();
        drv0(1'b0, 8'h00, 1'b0); #1;
        check("tie_gap_grant", {14'd0, grant}, 16'd0);
        check("tie_gap_wr", {15'd0, fifo_wr}, 16'd0);
        tick(); #1;
        check("tie_second", {14'd0, grant}, 16'd2);
        check("tie_data1", {8'd0, fifo_wdata}, 16'h31);
        check("tie_rdy1", {15'd0, req1_ready}, 16'd1);
        check("tie_rdy0_held", {15'd0, req0_ready}, 16'd0);
        tick();
        drv1(1'b0, 8'h00, 1'b0);
        // last_owner is now 1: another tie must go to req0
        drv0(1'b1, 8'h32, 1'b1);
        drv1(1'b1, 8'h33, 1'b1); #1;
        tick(); #1;
        check("tie_again_req0", {14'd0, grant}, 16'd1);

        // ---- fifo_full held for 5 cycles mid-packet ----
        do_reset();
        drv0(1'b1, 8'h51, 1'b0);
        tick(); #1;
        check("full_wr_first", {15'd0, fifo_wr}, 16'd1);
        check("full_data_first", {8'd0, fifo_wdata}, 16'h51);
        tick();
        drv0(1'b1, 8'h52, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_no_wr", {15'd0, fifo_wr}, 16'd0);
            check("full_no_rdy", {15'd0, req0_ready}, 16'd0);
            check("full_grant", {14'd0, grant}, 16'd1);
            check("full_data_hold", {8'd0, fifo_wdata}, 16'h52);
            tick();
        end
        fifo_full = 1'b0; #1;
        check("full_resume_wr", {15'd0, fifo_wr}, 16'd1);
        check("full_resume_data", {8'd0, fifo_wdata}, 16'h52);
        tick();
        drv0(1'b1, 8'h53, 1'b1); #1;
        check("full_next_data", {8'd0, fifo_wdata}, 16'h53);
        check("full_next_wr", {15'd0, fifo_wr}, 16'd1);
        tick();
        drv0(1'b0, 8'h00, 1'b0); #1;
        check("full_release", {14'd0, grant}, 16'd0);
        tick();

        // ---- Burst limit 4: req0 streams 6 bytes, req1 waits ----
        do_reset();
        drv0(1'b1, 8'h10, 1'b0);
        drv1(1'b1, 8'h77, 1'b1); #1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drv0(1'b1, 8'h10 + 8'(i), 1'b0); #1;
            check("burst_grant0", {14'd0, grant}, 16'd1);
            check("burst_data0", {8'd0, fifo_wdata}, 16'h10 + 16'(i));
            check("burst_wr0", {15'd0, fifo_wr}, 16'd1);
            check("burst_rdy1_held", {15'd0, req1_ready}, 16'd0);
            tick();
        end
        drv0(1'b1, 8'h14, 1'b0); #1;
        check("burst_idle", {14'd0, grant}, 16'd0);
        tick(); #1;
        check("burst_grant1", {14'd0, grant}, 16'd2);
        check("burst_data1", {8'd0, fifo_wdata}, 16'h77);
        check("burst_rdy0_held", {15'd0, req0_ready}, 16'd0);
        tick();
        drv1(1'b0, 8'h00, 1'b0); #1;
        check("burst_idle2", {14'd0, grant}, 16'd0);
        tick(); #1;
        check("burst_regrant0", {14'd0, grant}, 16'd1);
        check("burst_data_14", {8'd0, fifo_wdata}, 16'h14);
        tick();
        drv0(1'b1, 8'h15, 1'b1); #1;
        check("burst_data_15", {8'd0, fifo_wdata}, 16'h15);
        tick();
        drv0(1'b0, 8'h00, 1'b0); #1;
        check("burst_done", {14'd0, grant}, 16'd0);
        tick();

        // ---- Reset asserted while req1 owns mid-packet ----
        do_reset();
        drv1(1'b1, 8'h61, 1'b0);
        tick(); #1;
        check("rst1_grant", {14'd0, grant}, 16'd2);
        tick();
        drv1(1'b1, 8'h62, 1'b0); #1;
        check("rst1_wr_before", {15'd0, fifo_wr}, 16'd1);
        reset = 1'b0; #1;
        check("rst1_wr_async", {15'd0, fifo_wr}, 16'd0);
        check("rst1_grant_async", {14'd0, grant}, 16'd0);
        tick();
        reset = 1'b1;
        drv0(1'b1, 8'h70, 1'b1); #1;
        check("rst1_idle", {14'd0, grant}, 16'd0);
        tick(); #1;
        check("rst1_tie_req0", {14'd0, grant}, 16'd1);
        check("rst1_tie_data", {8'd0, fifo_wdata}, 16'h70);

`ifdef UART_TX_CRLF_EN
        // ---- CR inserted before LF ----
        do_reset();
        drv0(1'b1, 8'h61, 1'b0);
        tick(); #1;
        check("crlf_a", {8'd0, fifo_wdata}, 16'h61);
        check("crlf_a_rdy", {15'd0, req0_ready}, 16'd1);
        tick();
        drv0(1'b1, 8'h0A, 1'b1); #1;
        check("crlf_cr", {8'd0, fifo_wdata}, 16'h0D);
        check("crlf_cr_wr", {15'd0, fifo_wr}, 16'd1);
        check("crlf_cr_rdy", {15'd0, req0_ready}, 16'd0);
        tick(); #1;
        check("crlf_lf", {8'd0, fifo_wdata}, 16'h0A);
        check("crlf_lf_rdy", {15'd0, req0_ready}, 16'd1);
        check("crlf_cr_uncounted", 16'(dut.burst_reg), 16'd1);
        tick();
        drv0(1'b0, 8'h00, 1'b0); #1;
        check("crlf_release", {14'd0, grant}, 16'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit FIFO write port between two byte-stream requesters: requester 0 is the CPU's memory-mapped UART data register, requester 1 is the boot/monitor echo path. Grants are round-robin and held for a packet, so text from the two sources never interleaves mid-line. It sits between the requesters and the UART's tx FIFO write side, and it obeys the FIFO's full flag.

Parameters:
MAX_BURST, 16, maximum bytes one grant may transfer before it is forcibly released (range 1..255).
BURST_W, $clog2(MAX_BURST+1), width of the burst counter (derived; do not override).

Ports:
clk  in  1  system clock (16 MHz).
reset  in  1  asynchronous reset, active-low: 0 = in reset.
req0_valid  in  1  requester 0 has a byte.
req0_data  in  8  requester 0 byte.
req0_last  in  1  this byte ends requester 0's packet.
req0_ready  out  1  requester 0 byte accepted this cycle when valid & ready.
req1_valid  in  1  requester 1 has a byte.
req1_data  in  8  requester 1 byte.
req1_last  in  1  this byte ends requester 1's packet.
req1_ready  out  1  requester 1 accept.
fifo_full  in  1  UART tx FIFO full.
fifo_wr  out  1  write strobe to the tx FIFO.
fifo_wdata  out  8  byte written to the tx FIFO.
grant  out  2  one-hot current owner; 2'b00 when idle.

Behaviour:
- State machine IDLE / OWN0 / OWN1. Registers: state, burst counter, last_owner. With CRLF insertion compiled in, add cr_sent.
- Reset (reset = 0, asynchronous): state = IDLE, burst counter = 0, last_owner = 1 (so requester 0 wins the first tie). All outputs are 0 while in reset and immediately after it.
- IDLE:
  - Only one requester valid: go to that requester's OWN state.
  - Both valid: grant the requester that is not last_owner.
  - No transfer happens in IDLE, so arbitration costs one cycle.
- OWNn:
  - grant = one-hot n.
  - reqn_ready = reqn_valid & ~fifo_full. Ready is combinational.
  - fifo_wr = reqn_valid & reqn_ready, and fifo_wdata = reqn_data in the same cycle (zero latency).
  - The other requester's ready is held at 0.
- Each transfer increments the burst counter.
- The grant is released to IDLE on the clock edge after a transfer where either:
  - reqn_last = 1, or
  - the counter reaches MAX_BURST.
- On release: last_owner = n and the counter is cleared.
- An owner that drops valid does not lose the grant. Only last or the burst limit releases it, except as noted for MAX_BURST = 1 below.
- fifo_full while owning: no write and ready = 0. State and counter hold, and the requester's byte must remain stable.
- Simultaneous last and burst-limit on the same transfer: a single release, same as either alone.
- MAX_BURST = 1: every byte releases the grant, giving strict byte-level round-robin.
- A requester asserting valid on the release cycle is seen in IDLE on the next cycle. The earliest write after a release is therefore two cycles after the last write.
- fifo_wr is never asserted while fifo_full = 1.

Optional Feature:
UART_TX_CRLF_EN.
- Defined: when the owner presents 0x0A and cr_sent = 0, the block does the following:
  - writes 0x0D with reqn_ready = 0 and sets cr_sent;
  - on the next non-full cycle, writes 0x0A with reqn_ready = 1 and clears cr_sent.
- The CR does not count toward the burst limit, and a release never separates the CR from its LF.
- Reset clears cr_sent.
- Undefined: bytes pass unmodified and cr_sent does not exist.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (ARB_IDLE, ARB_OWN0, ARB_OWN1);
  - constants ASCII_LF = 8'h0A and ASCII_CR = 8'h0D;
  - the byte width of 8.
- No sub-module: the mux and FSM are small enough to stay in one module. Grant logic stays inline.

Test Plan:
- Reset, then only req0 sends "AB" with last on 'B': writes 0x41 and 0x42 on consecutive cycles starting one cycle after valid; grant returns to 00; req1_ready stays 0 throughout.
- Both requesters valid from reset, each sending a single byte with last = 1: req0 is granted first, then req1; the FIFO receives req0's byte, then req1's; last_owner ends at 1.
- fifo_full is held high for 5 cycles mid-packet: no fifo_wr, ready stays 0, and the data holds; the writes resume after full drops with no byte lost or duplicated.
- MAX_BURST = 4, req0 sends 6 bytes without last while req1 waits: 4 bytes from req0, then req1's packet, then req0's remaining 2.
- Reset asserted in OWN1 mid-packet: fifo_wr and grant go to 0 immediately; after reset, a tie is granted to req0.
- With UART_TX_CRLF_EN, req0 sends "a\n" with last on LF: the FIFO receives 0x61, 0x0D, 0x0A; req0_ready is 0 on the CR cycle; the burst count is 2.
